// File: rtl/ibex_rf_pkg.sv
// ibex_rf_pkg: shared writeback-source encoding and register-file address width helper
package ibex_rf_pkg;
  typedef enum logic [1:0] {WB_NONE, WB_LSU, WB_SKID, WB_EX} wb_src_e;
  function automatic int unsigned addr_width(bit rv32e);
    return rv32e ? 4 : 5;
  endfunction
endpackage

// File: rtl/ibex_rf_scoreboard.sv
// ibex_rf_scoreboard: pending-load bit per register (set on issue, cleared on return, set wins), two lookup ports, any-pending flag
module ibex_rf_scoreboard #(
  parameter int AW = 5
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          set_i,
  input  logic [AW-1:0] set_addr_i,
  input  logic          clr_i,
  input  logic [AW-1:0] clr_addr_i,
  input  logic [AW-1:0] raddr_a_i,
  input  logic [AW-1:0] raddr_b_i,
  output logic          pend_a_o,
  output logic          pend_b_o,
  output logic          any_o
);
  localparam int NW = 2 ** AW;
  logic [NW-1:1] pend_q;
  logic [NW-1:0] pend_all;
  assign pend_all = {pend_q, 1'b0};
  always_ff @(posedge clk_i) begin
    if (rst_i) pend_q <= '0;
    else
      for (int i = 1; i < NW; i++)
        if (set_i && set_addr_i == AW'(i)) pend_q[i] <= 1'b1;
        else if (clr_i && clr_addr_i == AW'(i)) pend_q[i] <= 1'b0;
  end
  assign pend_a_o = pend_all[raddr_a_i];
  assign pend_b_o = pend_all[raddr_b_i];
  assign any_o    = |pend_q;
endmodule

// File: rtl/ibex_rf_wb_arbiter.sv
// ibex_rf_wb_arbiter: shares the RF write port between LSU (priority) and EX (via one-entry skid); exports load RAW hazards, busy
module ibex_rf_wb_arbiter
  import ibex_rf_pkg::*;
#(
  parameter bit RV32E     = 1'b0,
  parameter int DataWidth = 32
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 ex_valid_i,
  output logic                 ex_ready_o,
  input  logic [4:0]           ex_waddr_i,
  input  logic [DataWidth-1:0] ex_wdata_i,
  input  logic                 lsu_issue_i,
  input  logic [4:0]           lsu_issue_waddr_i,
  input  logic                 lsu_valid_i,
  input  logic [4:0]           lsu_waddr_i,
  input  logic [DataWidth-1:0] lsu_wdata_i,
  input  logic [4:0]           raddr_a_i,
  input  logic [4:0]           raddr_b_i,
  output logic                 hazard_a_o,
  output logic                 hazard_b_o,
  output logic [4:0]           rf_waddr_o,
  output logic [DataWidth-1:0] rf_wdata_o,
  output logic                 rf_we_o,
  output logic                 busy_o
);
  localparam int AW = addr_width(RV32E);
  logic                 skid_valid;
  logic [4:0]           skid_waddr;
  logic [DataWidth-1:0] skid_wdata;
  logic                 ex_fire;
  logic                 pend_a;
  logic                 pend_b;
  logic                 pend_any;
  wb_src_e              src;
  assign ex_ready_o = !rst_i && !skid_valid;
  assign ex_fire    = ex_valid_i && ex_ready_o;
  always_comb begin
    src = rst_i ? WB_NONE : lsu_valid_i ? WB_LSU : skid_valid ? WB_SKID : ex_fire ? WB_EX : WB_NONE;
    rf_waddr_o = src == WB_LSU ? lsu_waddr_i : src == WB_SKID ? skid_waddr : ex_waddr_i;
    rf_wdata_o = src == WB_LSU ? lsu_wdata_i : src == WB_SKID ? skid_wdata : ex_wdata_i;
    rf_we_o    = src != WB_NONE && rf_waddr_o[AW-1:0] != '0;
  end
  always_ff @(posedge clk_i) begin
    if (rst_i) skid_valid <= 1'b0;
    else if (skid_valid && !lsu_valid_i) skid_valid <= 1'b0;
    else if (ex_fire && lsu_valid_i) begin
      skid_valid <= 1'b1;
      skid_waddr <= ex_waddr_i;
      skid_wdata <= ex_wdata_i;
    end
  end
  ibex_rf_scoreboard #(.AW(AW)) u_scoreboard (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .set_i      (lsu_issue_i),
    .set_addr_i (lsu_issue_waddr_i[AW-1:0]),
    .clr_i      (lsu_valid_i),
    .clr_addr_i (lsu_waddr_i[AW-1:0]),
    .raddr_a_i  (raddr_a_i[AW-1:0]),
    .raddr_b_i  (raddr_b_i[AW-1:0]),
    .pend_a_o   (pend_a),
    .pend_b_o   (pend_b),
    .any_o      (pend_any)
  );
  assign hazard_a_o = !rst_i && raddr_a_i[AW-1:0] != '0 &&
                      (pend_a || (skid_valid && skid_waddr[AW-1:0] == raddr_a_i[AW-1:0]));
  assign hazard_b_o = !rst_i && raddr_b_i[AW-1:0] != '0 &&
                      (pend_b || (skid_valid && skid_waddr[AW-1:0] == raddr_b_i[AW-1:0]));
  assign busy_o     = !rst_i && (pend_any || skid_valid);
endmodule

// File: tb/tb_ibex_rf_wb_arbiter.sv
// tb_ibex_rf_wb_arbiter: directed and random checks of the writeback arbiter against a queue-based reference model
module tb_ibex_rf_wb_arbiter;
  logic        clk = 1'b0;
  logic        rst, ex_v, iss, lv, ex_rdy, haz_a, haz_b, we, busy;
  logic [4:0]  ex_a, iss_a, la, ra, rb, wa;
  logic [31:0] ex_d, ld, wd;
  int          checks = 0;
  int          errors = 0;
  typedef struct {bit [4:0] a; bit [31:0] d;} ent_t;
  ent_t        sq[$];
  bit   [31:0] pend;
  always #5 clk = ~clk;
  ibex_rf_wb_arbiter dut (
    .clk_i(clk), .rst_i(rst),
    .ex_valid_i(ex_v), .ex_ready_o(ex_rdy), .ex_waddr_i(ex_a), .ex_wdata_i(ex_d),
    .lsu_issue_i(iss), .lsu_issue_waddr_i(iss_a),
    .lsu_valid_i(lv), .lsu_waddr_i(la), .lsu_wdata_i(ld),
    .raddr_a_i(ra), .raddr_b_i(rb), .hazard_a_o(haz_a), .hazard_b_o(haz_b),
    .rf_waddr_o(wa), .rf_wdata_o(wd), .rf_we_o(we), .busy_o(busy)
  );
  task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h at %0t", tag, got, exp, $time);
    end
  endtask
  task automatic drv(bit r, bit ev, bit [4:0] ea, bit [31:0] ed, bit is, bit [4:0] ia,
                     bit l, bit [4:0] lad, bit [31:0] ldd, bit [4:0] a, bit [4:0] b);
    rst = r; ex_v = ev; ex_a = ea; ex_d = ed; iss = is; iss_a = ia;
    lv = l; la = lad; ld = ldd; ra = a; rb = b;
  endtask
  function automatic bit mhaz(bit [4:0] r);
    return r != 0 && (pend[r] || (sq.size() != 0 && sq[0].a == r));
  endfunction
  task automatic step();
    bit        rdy, has, ewe;
    bit [4:0]  ea;
    bit [31:0] ed;
    #1;
    rdy = !rst && sq.size() == 0;
    has = 0; ea = 0; ed = 0;
    if (!rst) begin
      if (lv) begin has = 1; ea = la; ed = ld; end
      else if (sq.size() != 0) begin has = 1; ea = sq[0].a; ed = sq[0].d; end
      else if (ex_v && rdy) begin has = 1; ea = ex_a; ed = ex_d; end
    end
    ewe = has && ea != 0;
    chk("rf_we", we, ewe);
    if (ewe) begin
      chk("rf_waddr", wa, ea);
      chk("rf_wdata", wd, ed);
    end
    chk("ex_ready", ex_rdy, rdy);
    chk("hazard_a", haz_a, !rst && mhaz(ra));
    chk("hazard_b", haz_b, !rst && mhaz(rb));
    chk("busy", busy, !rst && (pend != 0 || sq.size() != 0));
    if (rst) begin
      pend = 0;
      sq.delete();
    end else begin
      if (sq.size() != 0 && !lv) void'(sq.pop_front());
      if (ex_v && rdy && lv) sq.push_back('{ex_a, ex_d});
      if (lv) pend[la] = 0;
      if (iss && iss_a != 0) pend[iss_a] = 1;
    end
    @(negedge clk);
  endtask
  task automatic idle(bit [4:0] a, bit [4:0] b);
    drv(0, 0, 0, 0, 0, 0, 0, 0, 0, a, b);
  endtask
  initial begin
    bit [4:0] cand[$];
    pend = 0;
    drv(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    step(); step();
    // EX only
    drv(0, 1, 5, 32'hDEADBEEF, 0, 0, 0, 0, 0, 5, 0);
    #1;
    chk("exonly_we", we, 1); chk("exonly_waddr", wa, 5);
    chk("exonly_wdata", wd, 32'hDEADBEEF); chk("exonly_rdy", ex_rdy, 1);
    step();
    idle(0, 0); #1; chk("exonly_busy", busy, 0); step();
    // collision
    drv(0, 0, 0, 0, 1, 3, 0, 0, 0, 0, 0); step();
    drv(0, 1, 7, 32'h22, 0, 0, 1, 3, 32'h11, 0, 0);
    #1; chk("coll_c0_waddr", wa, 3); chk("coll_c0_rdy", ex_rdy, 1); step();
    idle(7, 0);
    #1; chk("coll_c1_waddr", wa, 7); chk("coll_c1_wdata", wd, 32'h22);
    chk("coll_c1_rdy", ex_rdy, 0); chk("coll_c1_haz", haz_a, 1); step();
    idle(7, 0); #1; chk("coll_c2_rdy", ex_rdy, 1); chk("coll_c2_haz", haz_a, 0); step();
    // back-to-back LSU with skid held
    for (int i = 3; i <= 6; i++) begin drv(0, 0, 0, 0, 1, 5'(i), 0, 0, 0, 0, 0); step(); end
    drv(0, 1, 7, 32'h77, 0, 0, 1, 3, 32'h33, 7, 8); step();
    for (int i = 4; i <= 6; i++) begin
      drv(0, 1, 8, 32'h88, 0, 0, 1, 5'(i), 32'(i * 16'h1111), 7, 8);
      #1; chk("b2b_stall", ex_rdy, 0); step();
    end
    drv(0, 1, 8, 32'h88, 0, 0, 0, 0, 0, 7, 8);
    #1; chk("b2b_drain_waddr", wa, 7); chk("b2b_drain_rdy", ex_rdy, 0); step();
    drv(0, 1, 8, 32'h88, 0, 0, 0, 0, 0, 7, 8);
    #1; chk("b2b_ex_waddr", wa, 8); chk("b2b_ex_rdy", ex_rdy, 1); step();
    // scoreboard
    drv(0, 0, 0, 0, 1, 9, 0, 0, 0, 9, 0); #1; chk("sb_haz_pre", haz_a, 0); step();
    idle(9, 0); #1; chk("sb_haz_set", haz_a, 1); step();
    drv(0, 0, 0, 0, 0, 0, 1, 9, 32'h9, 9, 0); step();
    idle(9, 0); #1; chk("sb_haz_clr", haz_a, 0); step();
    drv(0, 0, 0, 0, 1, 9, 0, 0, 0, 9, 9); step();
    drv(0, 0, 0, 0, 1, 9, 1, 9, 32'h99, 9, 9); step();
    idle(9, 9); #1; chk("sb_set_wins", haz_b, 1); step();
    drv(0, 0, 0, 0, 0, 0, 1, 9, 32'h9, 0, 0); step();
    // x0
    drv(0, 1, 0, 32'h1234, 1, 0, 0, 0, 0, 0, 0);
    #1; chk("x0_we", we, 0); chk("x0_rdy", ex_rdy, 1); step();
    idle(0, 0); #1; chk("x0_busy", busy, 0); chk("x0_haz", haz_a, 0); step();
    // reset mid-operation
    drv(0, 0, 0, 0, 1, 4, 0, 0, 0, 0, 0); step();
    drv(0, 0, 0, 0, 1, 12, 0, 0, 0, 0, 0); step();
    drv(0, 0, 0, 0, 1, 13, 0, 0, 0, 0, 0); step();
    drv(0, 1, 7, 32'h7, 0, 0, 1, 13, 32'hd, 4, 12); step();
    drv(1, 0, 0, 0, 0, 0, 0, 0, 0, 4, 12); step();
    idle(4, 12);
    #1; chk("rst_busy", busy, 0); chk("rst_haz_a", haz_a, 0);
    chk("rst_haz_b", haz_b, 0); chk("rst_rdy", ex_rdy, 1); step();
    // random, neighbour rules respected
    for (int n = 0; n < 3000; n++) begin
      bit [4:0] e, ia, l;
      bit       ev, is, lvv;
      cand.delete();
      for (int r = 1; r < 32; r++) if (pend[r]) cand.push_back(5'(r));
      lvv = cand.size() != 0 && $urandom_range(0, 9) < 4;
      l   = lvv ? cand[$urandom_range(0, cand.size() - 1)] : 5'($urandom);
      do e = 5'($urandom); while (pend[e]);
      do ia = 5'($urandom); while (pend[ia]);
      if ($urandom_range(0, 9) == 0) ia = 0;
      ev = $urandom_range(0, 1) == 1;
      is = $urandom_range(0, 9) < 3;
      drv($urandom_range(0, 199) == 0, ev, e, $urandom, is, ia, lvv, l, $urandom,
          5'($urandom), $urandom_range(0, 1) ? sq.size() != 0 ? sq[0].a : 5'($urandom) : 5'($urandom));
      step();
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
